// File: rtl/ram_dat_ctrl.sv
// Data RAM sequencer: arbitrates CPU word accesses, line fills and line evictions
// onto the shared per-way RAM command port and steers read data back.
module ram_dat_ctrl #(
  parameter int WAYS_N     = 4,
  parameter int SETS_N     = 32,
  parameter int LINE_WORDS = 8,
  parameter int W          = 32,
  parameter int ADDR_W     = $clog2(SETS_N*LINE_WORDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cpu_req_valid,
  output logic                        cpu_req_ready,
  input  logic [$clog2(WAYS_N)-1:0]   cpu_req_way,
  input  logic                        cpu_req_wen,
  input  logic [ADDR_W-1:0]           cpu_req_addr,
  input  logic [W-1:0]                cpu_req_wdata,
  output logic                        cpu_resp_valid,
  output logic [W-1:0]                cpu_resp_rdata,
  input  logic                        fill_start,
  input  logic [$clog2(WAYS_N)-1:0]   fill_way,
  input  logic [$clog2(SETS_N)-1:0]   fill_set,
  input  logic                        fill_data_valid,
  output logic                        fill_data_ready,
  input  logic [W-1:0]                fill_data,
  output logic                        fill_done,
  input  logic                        evict_start,
  input  logic [$clog2(WAYS_N)-1:0]   evict_way,
  input  logic [$clog2(SETS_N)-1:0]   evict_set,
  output logic                        evict_data_valid,
  input  logic                        evict_data_ready,
  output logic [W-1:0]                evict_data,
  output logic                        evict_last,
  output logic                        busy,
  output logic [WAYS_N-1:0]           ram_en,
  output logic [WAYS_N-1:0]           ram_wen,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [W-1:0]                ram_wdata,
  input  logic [WAYS_N*W-1:0]         ram_rdata
);

  localparam int WAY_W = $clog2(WAYS_N);
  localparam int SET_W = $clog2(SETS_N);
  localparam int CNT_W = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_WORDS-1);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_EVICT_RD, S_EVICT_WT} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WAY_W-1:0]   r_way, r_pend_way, r_resp_way;
  logic [SET_W-1:0]   r_set, r_pend_set;
  logic               r_pend;
  logic               r_resp_valid;
  logic               r_ev_valid, r_ev_first, r_ev_last;
  logic [W-1:0]       r_ev_data;

  logic               w_cpu_acc, w_fill_beat, w_ev_hs, w_cnt_last;
  logic               w_en_sel, w_wen_sel;
  logic [WAY_W-1:0]   w_way_sel;
  logic [W-1:0]       w_rd_way;

  assign w_cnt_last  = (r_cnt == LAST);
  assign w_cpu_acc   = cpu_req_valid && cpu_req_ready;
  assign w_fill_beat = (r_state == S_FILL) && fill_data_valid;
  assign w_ev_hs     = (r_state == S_EVICT_WT) && r_ev_valid && evict_data_ready;
  assign w_rd_way    = ram_rdata[r_way*W +: W];

  assign cpu_req_ready   = (r_state == S_IDLE) && !fill_start && !evict_start && !r_pend;
  assign cpu_resp_valid  = r_resp_valid;
  assign cpu_resp_rdata  = ram_rdata[r_resp_way*W +: W];
  assign fill_data_ready = (r_state == S_FILL);
  assign fill_done       = w_fill_beat && w_cnt_last;
  assign busy            = (r_state != S_IDLE) || r_pend;
  assign evict_data_valid = r_ev_valid;
  assign evict_last      = r_ev_last;
  // First beat cycle forwards the RAM output; later stall cycles replay the captured copy.
  assign evict_data      = r_ev_first ? w_rd_way : r_ev_data;

  assign ram_en  = w_en_sel ? (WAYS_N'(1) << w_way_sel) : '0;
  assign ram_wen = (w_en_sel && w_wen_sel) ? (WAYS_N'(1) << w_way_sel) : '0;

  always_comb begin
    w_next    = r_state;
    w_en_sel  = 1'b0;
    w_wen_sel = 1'b0;
    w_way_sel = r_way;
    ram_addr  = {r_set, r_cnt};
    ram_wdata = fill_data;
    unique case (r_state)
      S_IDLE: begin
        if (r_pend)           w_next = S_FILL;
        else if (evict_start) w_next = S_EVICT_RD;
        else if (fill_start)  w_next = S_FILL;
        if (w_cpu_acc) begin
          w_en_sel  = 1'b1;
          w_wen_sel = cpu_req_wen;
          w_way_sel = cpu_req_way;
          ram_addr  = cpu_req_addr;
          ram_wdata = cpu_req_wdata;
        end
      end
      S_FILL: begin
        if (fill_data_valid) begin
          w_en_sel  = 1'b1;
          w_wen_sel = 1'b1;
          if (w_cnt_last) w_next = S_IDLE;
        end
      end
      S_EVICT_RD: begin
        w_en_sel = 1'b1;
        w_next   = S_EVICT_WT;
      end
      S_EVICT_WT: begin
        if (w_ev_hs) begin
          if (w_cnt_last) w_next = r_pend ? S_FILL : S_IDLE;
          else            w_next = S_EVICT_RD;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_way        <= '0;
      r_set        <= '0;
      r_pend       <= 1'b0;
      r_pend_way   <= '0;
      r_pend_set   <= '0;
      r_resp_valid <= 1'b0;
      r_resp_way   <= '0;
      r_ev_valid   <= 1'b0;
      r_ev_first   <= 1'b0;
      r_ev_last    <= 1'b0;
      r_ev_data    <= '0;
    end else begin
      r_state      <= w_next;
      r_resp_valid <= w_cpu_acc && !cpu_req_wen;
      if (w_cpu_acc) r_resp_way <= cpu_req_way;

      r_ev_first <= (r_state == S_EVICT_RD);
      if (r_ev_first) r_ev_data <= w_rd_way;
      if (r_state == S_EVICT_RD) begin
        r_ev_valid <= 1'b1;
        r_ev_last  <= w_cnt_last;
      end else if (w_ev_hs) begin
        r_ev_valid <= 1'b0;
        r_ev_last  <= 1'b0;
      end

      if (w_fill_beat || w_ev_hs) r_cnt <= w_cnt_last ? '0 : r_cnt + CNT_W'(1);

      unique case (r_state)
        S_IDLE: begin
          if (r_pend) begin
            r_way  <= r_pend_way;
            r_set  <= r_pend_set;
            r_pend <= 1'b0;
          end else if (evict_start) begin
            r_way <= evict_way;
            r_set <= evict_set;
            if (fill_start) begin
              r_pend     <= 1'b1;
              r_pend_way <= fill_way;
              r_pend_set <= fill_set;
            end
          end else if (fill_start) begin
            r_way <= fill_way;
            r_set <= fill_set;
          end
        end
        S_EVICT_RD, S_EVICT_WT: begin
          if (w_ev_hs && w_cnt_last && r_pend) begin
            r_way  <= r_pend_way;
            r_set  <= r_pend_set;
            r_pend <= 1'b0;
          end else if (fill_start && !r_pend) begin
            r_pend     <= 1'b1;
            r_pend_way <= fill_way;
            r_pend_set <= fill_set;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_dat_ctrl.sv
// Bench for ram_dat_ctrl: behavioural RAM array plus a shadow memory of intended
// line/word contents against which loads and eviction beats are compared.
module tb_ram_dat_ctrl;
  localparam int WAYS_N     = 4;
  localparam int SETS_N     = 32;
  localparam int LINE_WORDS = 8;
  localparam int W          = 32;
  localparam int ADDR_W     = $clog2(SETS_N*LINE_WORDS);
  localparam int DEPTH      = SETS_N*LINE_WORDS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                cpu_req_valid, cpu_req_ready, cpu_req_wen;
  logic [1:0]          cpu_req_way;
  logic [ADDR_W-1:0]   cpu_req_addr;
  logic [W-1:0]        cpu_req_wdata;
  logic                cpu_resp_valid;
  logic [W-1:0]        cpu_resp_rdata;
  logic                fill_start, fill_data_valid, fill_data_ready, fill_done;
  logic [1:0]          fill_way;
  logic [4:0]          fill_set;
  logic [W-1:0]        fill_data;
  logic                evict_start, evict_data_valid, evict_data_ready, evict_last;
  logic [1:0]          evict_way;
  logic [4:0]          evict_set;
  logic [W-1:0]        evict_data;
  logic                busy;
  logic [WAYS_N-1:0]   ram_en, ram_wen;
  logic [ADDR_W-1:0]   ram_addr;
  logic [W-1:0]        ram_wdata;
  logic [WAYS_N*W-1:0] ram_rdata;

  ram_dat_ctrl #(.WAYS_N(WAYS_N), .SETS_N(SETS_N), .LINE_WORDS(LINE_WORDS), .W(W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_way(cpu_req_way),
    .cpu_req_wen(cpu_req_wen), .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
    .cpu_resp_valid(cpu_resp_valid), .cpu_resp_rdata(cpu_resp_rdata),
    .fill_start(fill_start), .fill_way(fill_way), .fill_set(fill_set),
    .fill_data_valid(fill_data_valid), .fill_data_ready(fill_data_ready), .fill_data(fill_data),
    .fill_done(fill_done),
    .evict_start(evict_start), .evict_way(evict_way), .evict_set(evict_set),
    .evict_data_valid(evict_data_valid), .evict_data_ready(evict_data_ready),
    .evict_data(evict_data), .evict_last(evict_last), .busy(busy),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // Per-way single-port RAMs with registered read data.
  logic [W-1:0] mem     [WAYS_N][DEPTH];
  logic [W-1:0] ref_mem [WAYS_N][DEPTH];
  logic [W-1:0] rdq     [WAYS_N];

  always @(posedge clk)
    for (int g = 0; g < WAYS_N; g++)
      if (ram_en[g]) begin
        if (ram_wen[g]) mem[g][ram_addr] <= ram_wdata;
        else            rdq[g] <= mem[g][ram_addr];
      end

  for (genvar g = 0; g < WAYS_N; g++) begin : g_rd
    assign ram_rdata[g*W +: W] = rdq[g];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] way);
    return 4'(1) << way;
  endfunction

  task automatic cpu_single(input logic [1:0] way, input logic wen, input logic [7:0] addr,
                            input logic [31:0] wd);
    int n = 0;
    cpu_req_valid = 1'b1; cpu_req_way = way; cpu_req_wen = wen;
    cpu_req_addr = addr; cpu_req_wdata = wd;
    #1;
    while (!cpu_req_ready && n < 50) begin step(); n++; end
    chk("cpu_accept", cpu_req_ready, 1);
    chk("cpu_ram_en", ram_en, onehot(way));
    chk("cpu_ram_wen", ram_wen, wen ? onehot(way) : 4'b0);
    chk("cpu_ram_addr", ram_addr, addr);
    if (wen) chk("cpu_ram_wdata", ram_wdata, wd);
    step();
    cpu_req_valid = 1'b0;
    #1;
    chk("cpu_resp_valid", cpu_resp_valid, !wen);
    if (!wen) chk("cpu_resp_rdata", cpu_resp_rdata, ref_mem[way][addr]);
    else      ref_mem[way][addr] = wd;
  endtask

  task automatic fill_line(input logic [1:0] way, input logic [4:0] set, input logic [31:0] base,
                           input int gap_after, input int gap_len, input bit do_start, input bit rnd);
    logic [31:0] d;
    logic [7:0]  a;
    if (do_start) begin
      fill_start = 1'b1; fill_way = way; fill_set = set;
      #1;
      chk("fill_start_cpu_ready", cpu_req_ready, 0);
      step();
      fill_start = 1'b0;
    end
    for (int b = 0; b < LINE_WORDS; b++) begin
      if (b == gap_after + 1)
        for (int g = 0; g < gap_len; g++) begin
          fill_data_valid = 1'b0;
          #1;
          chk("fill_gap_ram_en", ram_en, 0);
          chk("fill_gap_done", fill_done, 0);
          chk("fill_gap_busy", busy, 1);
          step();
        end
      d = rnd ? $urandom : base + 32'(b);
      a = {set, 3'(b)};
      fill_data_valid = 1'b1; fill_data = d;
      #1;
      chk("fill_ready", fill_data_ready, 1);
      chk("fill_ram_en", ram_en, onehot(way));
      chk("fill_ram_wen", ram_wen, onehot(way));
      chk("fill_ram_addr", ram_addr, a);
      chk("fill_ram_wdata", ram_wdata, d);
      chk("fill_done", fill_done, b == LINE_WORDS-1);
      chk("fill_cpu_ready", cpu_req_ready, 0);
      chk("fill_busy", busy, 1);
      ref_mem[way][a] = d;
      step();
    end
    fill_data_valid = 1'b0;
    #1;
    chk("fill_end_busy", busy, 0);
    chk("fill_end_done", fill_done, 0);
  endtask

  // mode 0: always ready, 1: ready toggles every two cycles, 2: random
  task automatic evict_line(input logic [1:0] way, input logic [4:0] set, input int mode,
                            input bit also_fill, input logic [1:0] fway, input logic [4:0] fset,
                            input bit abort);
    int beat = 0;
    int cyc  = 0;
    bit just_rd = 1'b1;
    bit aborted = 1'b0;
    logic [7:0] a;
    evict_start = 1'b1; evict_way = way; evict_set = set;
    if (also_fill) begin fill_start = 1'b1; fill_way = fway; fill_set = fset; end
    #1;
    chk("evict_start_cpu_ready", cpu_req_ready, 0);
    step();
    evict_start = 1'b0; fill_start = 1'b0;
    while (beat < LINE_WORDS && !aborted && cyc < 200) begin
      case (mode)
        0:       evict_data_ready = 1'b1;
        1:       evict_data_ready = ((cyc >> 1) & 1) == 1;
        default: evict_data_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      a = {set, 3'(beat)};
      chk("evict_busy", busy, 1);
      if (just_rd) begin
        chk("evict_rd_valid", evict_data_valid, 0);
        chk("evict_rd_en", ram_en, onehot(way));
        chk("evict_rd_wen", ram_wen, 0);
        chk("evict_rd_addr", ram_addr, a);
        just_rd = 1'b0;
      end else begin
        chk("evict_valid", evict_data_valid, 1);
        chk("evict_wt_en", ram_en, 0);
        chk("evict_data", evict_data, ref_mem[way][a]);
        chk("evict_last", evict_last, beat == LINE_WORDS-1);
        if (abort && beat == 4) begin
          rst = 1'b1;
          evict_data_ready = 1'b0;
          aborted = 1'b1;
        end else if (evict_data_ready) begin
          beat++;
          just_rd = (beat < LINE_WORDS);
        end
      end
      step();
      cyc++;
    end
    evict_data_ready = 1'b0;
    if (cyc >= 200) chk("evict_timeout", beat, LINE_WORDS);
    if (aborted) begin
      rst = 1'b0;
      #1;
      chk("rst_resp_valid", cpu_resp_valid, 0);
      chk("rst_fill_done", fill_done, 0);
      chk("rst_evict_valid", evict_data_valid, 0);
      chk("rst_evict_last", evict_last, 0);
      chk("rst_evict_data", evict_data, 0);
      chk("rst_ram_en", ram_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cpu_ready", cpu_req_ready, 1);
    end else if (also_fill) begin
      #1;
      chk("refill_follows_ready", fill_data_ready, 1);
      chk("refill_follows_busy", busy, 1);
      chk("refill_evict_valid", evict_data_valid, 0);
    end else begin
      #1;
      chk("evict_end_busy", busy, 0);
      chk("evict_end_valid", evict_data_valid, 0);
      chk("evict_end_cpu_ready", cpu_req_ready, 1);
    end
  endtask

  typedef struct {
    logic        wen;
    logic [1:0]  way;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  exp_en;
    logic [3:0]  exp_wen;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        prev_load;
    logic [31:0] prev_exp;
    logic [31:0] v;
    int          op;
    logic [1:0]  rw;
    logic [4:0]  rs;

    tbl[0] = '{1'b1, 2'd2, 8'h15, 32'hDEADBEEF, 4'b0100, 4'b0100, 32'h0};
    tbl[1] = '{1'b0, 2'd2, 8'h15, 32'h0,        4'b0100, 4'b0000, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 2'd0, 8'h00, 32'h11111111, 4'b0001, 4'b0001, 32'h0};
    tbl[3] = '{1'b1, 2'd3, 8'hFF, 32'hA5A5A5A5, 4'b1000, 4'b1000, 32'h0};
    tbl[4] = '{1'b0, 2'd3, 8'hFF, 32'h0,        4'b1000, 4'b0000, 32'hA5A5A5A5};
    tbl[5] = '{1'b0, 2'd0, 8'h00, 32'h0,        4'b0001, 4'b0000, 32'h11111111};
    tbl[6] = '{1'b1, 2'd2, 8'h15, 32'h12345678, 4'b0100, 4'b0100, 32'h0};
    tbl[7] = '{1'b0, 2'd2, 8'h15, 32'h0,        4'b0100, 4'b0000, 32'h12345678};

    for (int g = 0; g < WAYS_N; g++) begin
      rdq[g] = '0;
      for (int a = 0; a < DEPTH; a++) begin
        v = $urandom;
        mem[g][a] = v;
        ref_mem[g][a] = v;
      end
    end

    rst = 1'b1;
    cpu_req_valid = 0; cpu_req_way = 0; cpu_req_wen = 0; cpu_req_addr = 0; cpu_req_wdata = 0;
    fill_start = 0; fill_way = 0; fill_set = 0; fill_data_valid = 0; fill_data = 0;
    evict_start = 0; evict_way = 0; evict_set = 0; evict_data_ready = 0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    chk("reset_resp_valid", cpu_resp_valid, 0);
    chk("reset_evict_valid", evict_data_valid, 0);
    chk("reset_evict_last", evict_last, 0);
    chk("reset_evict_data", evict_data, 0);
    chk("reset_fill_done", fill_done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cpu_ready", cpu_req_ready, 1);
    chk("reset_ram_en", ram_en, 0);

    // Back-to-back CPU accesses from the vector table.
    prev_load = 1'b0;
    prev_exp  = '0;
    for (int i = 0; i < 8; i++) begin
      cpu_req_valid = 1'b1; cpu_req_wen = tbl[i].wen; cpu_req_way = tbl[i].way;
      cpu_req_addr = tbl[i].addr; cpu_req_wdata = tbl[i].wdata;
      #1;
      chk("tbl_ready", cpu_req_ready, 1);
      chk("tbl_ram_en", ram_en, tbl[i].exp_en);
      chk("tbl_ram_wen", ram_wen, tbl[i].exp_wen);
      chk("tbl_ram_addr", ram_addr, tbl[i].addr);
      if (tbl[i].wen) chk("tbl_ram_wdata", ram_wdata, tbl[i].wdata);
      chk("tbl_resp_valid", cpu_resp_valid, prev_load);
      if (prev_load) chk("tbl_resp_rdata", cpu_resp_rdata, prev_exp);
      if (tbl[i].wen) ref_mem[tbl[i].way][tbl[i].addr] = tbl[i].wdata;
      prev_load = !tbl[i].wen;
      prev_exp  = tbl[i].exp_rd;
      step();
    end
    cpu_req_valid = 1'b0;
    #1;
    chk("tbl_resp_valid_last", cpu_resp_valid, prev_load);
    chk("tbl_resp_rdata_last", cpu_resp_rdata, prev_exp);
    step();

    fill_line(2'd1, 5'd3, 32'h100, 3, 2, 1'b1, 1'b0);
    step();
    evict_line(2'd1, 5'd3, 1, 1'b0, 2'd0, 5'd0, 1'b0);
    step();

    // Simultaneous evict and fill: eviction first, refill queued behind it.
    evict_line(2'd0, 5'd5, 0, 1'b1, 2'd0, 5'd5, 1'b0);
    fill_line(2'd0, 5'd5, 32'h500, 7, 0, 1'b0, 1'b0);
    step();

    // CPU load arriving with fill_start waits for the whole line.
    cpu_req_valid = 1'b1; cpu_req_wen = 1'b0; cpu_req_way = 2'd1; cpu_req_addr = 8'h1A;
    cpu_req_wdata = '0;
    fill_line(2'd1, 5'd3, 32'h200, 1, 1, 1'b1, 1'b0);
    chk("post_fill_cpu_ready", cpu_req_ready, 1);
    chk("post_fill_ram_en", ram_en, 4'b0010);
    chk("post_fill_ram_wen", ram_wen, 4'b0000);
    step();
    cpu_req_valid = 1'b0;
    #1;
    chk("post_fill_resp_valid", cpu_resp_valid, 1);
    chk("post_fill_resp_rdata", cpu_resp_rdata, 32'h202);
    step();

    evict_line(2'd1, 5'd3, 0, 1'b0, 2'd0, 5'd0, 1'b1);
    step();
    cpu_single(2'd1, 1'b0, 8'h1A, 32'h0);
    step();

    for (int it = 0; it < 40; it++) begin
      op = $urandom_range(0, 9);
      rw = 2'($urandom_range(0, 3));
      rs = 5'($urandom_range(0, 3));
      if (op < 6)      cpu_single(rw, 1'($urandom_range(0, 1)), {rs, 3'($urandom)}, $urandom);
      else if (op < 8) fill_line(rw, rs, 32'h0, $urandom_range(0, 7), $urandom_range(0, 2), 1'b1, 1'b1);
      else             evict_line(rw, rs, 2, 1'b0, 2'd0, 5'd0, 1'b0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
